mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one W-bit downstream resource (ALU operand port) among four requesters. It picks a requester, drives the select of a 4:1 data mux, and registers the chosen operand. It presents the operand on a valid/ready handshake and acknowledges the winning requester when the transfer completes. It sits between the four operand sources and the ALU input stage.

---
 rtl/mux4_rr_arbiter_pkg.sv | 14 +
 rtl/mux4_rr_arbiter_operand_mux4.sv | 29 ++
 rtl/mux4_rr_arbiter_rr_pick4.sv | 30 +++
 rtl/mux4_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg
// Shared constants and types for the round-robin operand arbiter.
//   NREQ    : number of requesters sharing the downstream operand port
//   state_e : arbiter state (IDLE = nobody owns the port, BUSY = owner holds it)
package mux4_rr_arbiter_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mux4_rr_arbiter_operand_mux4.sv
// operand_mux4
// W-bit 4:1 data multiplexer used to pick the winning operand.
// Ports:
//   d0..d3 : candidate operands
//   sel    : index of the operand to pass through
//   y      : selected operand
module operand_mux4 #(
  parameter int W = 8
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  always_comb begin
    y = d0;
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// rr_pick4
// Combinational round-robin search over four request lines.
// Ports:
//   req : request vector, bit i = requester i pending
//   ptr : index where the search starts (highest priority this round)
//   idx : first requesting index found searching ptr, ptr+1, ... mod 4
//   any : at least one request is pending
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  // Walk from the farthest candidate back toward ptr so the candidate
  // closest to ptr is the last one written and therefore wins.
  always_comb begin
    logic [1:0] cand;
    idx  = ptr;
    cand = ptr;
    any  = |req;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter sharing one W-bit operand port among four requesters.
// In IDLE it picks a winner starting from ptr, captures that requester's
// operand and moves to BUSY; in BUSY it holds the operand on a valid/ready
// handshake and acknowledges the owner on the transfer cycle.
// Ports:
//   clk, rst   : clock (rising edge) and synchronous active-high reset
//   req        : per-requester pending flags
//   din0..din3 : per-requester operands
//   sel        : index of current owner (mux select)
//   gnt        : one-hot owner, zero while IDLE
//   ack        : owner acknowledge, high on the cycle the transfer completes
//   out_valid  : registered operand valid
//   out_data   : registered operand
//   out_ready  : downstream accepts out_data when out_valid & out_ready
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int W    = 8,
  parameter int NREQ = mux4_rr_arbiter_pkg::NREQ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    din0,
  input  logic [W-1:0]    din1,
  input  logic [W-1:0]    din2,
  input  logic [W-1:0]    din3,
  output logic [1:0]      sel,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] ack,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  input  logic            out_ready
);

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;

  logic [1:0]      pick_idx;
  logic            pick_any;
  logic [1:0]      mux_sel;
  logic [W-1:0]    mux_y;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // While BUSY the mux follows the owner so the same path serves both
  // capture and any later inspection; in IDLE it follows the search result.
  assign mux_sel = (state_q == ST_BUSY) ? sel_q : pick_idx;

  operand_mux4 #(.W(W)) u_mux (
    .d0  (din0),
    .d1  (din1),
    .d2  (din2),
    .d3  (din3),
    .sel (mux_sel),
    .y   (mux_y)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          sel_d       = pick_idx;
          gnt_d       = NREQ'(1) << pick_idx;
          out_data_d  = mux_y;
          out_valid_d = 1'b1;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Operand is frozen at grant; req/din changes here are ignored.
        if (out_ready) begin
          out_valid_d = 1'b0;
          gnt_d       = '0;
          ptr_d       = sel_q + 2'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd0;
      sel_q       <= 2'd0;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ack       = (state_q == ST_BUSY) ? (gnt_q & {NREQ{out_ready}}) : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
// Directed bench for mux4_rr_arbiter: a vector table for reset, single
// request and full round-robin rotation, then hand-written sequences for
// backpressure, wrap-around and reset during a transfer.
module tb_mux4_rr_arbiter;

  localparam logic [31:0] DEF = 32'h13121110;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] din0, din1, din2, din3;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic [3:0] ack;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  int checks;
  int errors;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic        rdy;
    logic        e_valid;
    logic [1:0]  e_sel;
    logic        sel_chk;
    logic [3:0]  e_gnt;
    logic [3:0]  e_ack;
    logic [7:0]  e_data;
  } vec_t;

  vec_t vecs[15];

  mux4_rr_arbiter #(.W(8), .NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din0      (din0),
    .din1      (din1),
    .din2      (din2),
    .din3      (din3),
    .sel       (sel),
    .gnt       (gnt),
    .ack       (ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [3:0] rq,
                               input logic [31:0] d, input logic rdy);
    rst       = r;
    req       = rq;
    din0      = d[7:0];
    din1      = d[15:8];
    din2      = d[23:16];
    din3      = d[31:24];
    out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic e_valid, input logic [1:0] e_sel,
                             input logic sel_chk, input logic [3:0] e_gnt,
                             input logic [3:0] e_ack, input logic [7:0] e_data);
    cmp({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, e_valid});
    if (sel_chk) cmp({tag, ".sel"}, {6'd0, sel}, {6'd0, e_sel});
    cmp({tag, ".gnt"}, {4'd0, gnt}, {4'd0, e_gnt});
    cmp({tag, ".ack"}, {4'd0, ack}, {4'd0, e_ack});
    cmp({tag, ".out_data"}, out_data, e_data);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset with every request up, single request from requester 2,
    // then a fresh reset and a full 0,1,2,3,0 rotation with req=1111.
    vecs[0]  = '{1'b1, 4'hF,    DEF,          1'b1, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 8'h00};
    vecs[1]  = '{1'b1, 4'hF,    DEF,          1'b1, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 8'h00};
    vecs[2]  = '{1'b0, 4'b0100, 32'h13A51110, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0100, 8'hA5};
    vecs[3]  = '{1'b0, 4'b0000, 32'h13A51110, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000, 4'b0000, 8'hA5};
    vecs[4]  = '{1'b1, 4'hF,    DEF,          1'b1, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 8'h00};
    vecs[5]  = '{1'b0, 4'hF,    DEF,          1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0001, 8'h10};
    vecs[6]  = '{1'b0, 4'hF,    DEF,          1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 8'h10};
    vecs[7]  = '{1'b0, 4'hF,    DEF,          1'b1, 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0010, 8'h11};
    vecs[8]  = '{1'b0, 4'hF,    DEF,          1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 8'h11};
    vecs[9]  = '{1'b0, 4'hF,    DEF,          1'b1, 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0100, 8'h12};
    vecs[10] = '{1'b0, 4'hF,    DEF,          1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 8'h12};
    vecs[11] = '{1'b0, 4'hF,    DEF,          1'b1, 1'b1, 2'd3, 1'b1, 4'b1000, 4'b1000, 8'h13};
    vecs[12] = '{1'b0, 4'hF,    DEF,          1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 8'h13};
    vecs[13] = '{1'b0, 4'hF,    DEF,          1'b1, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0001, 8'h10};
    vecs[14] = '{1'b0, 4'hF,    DEF,          1'b1, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 8'h10};

    applyStimulus(1'b1, 4'hF, DEF, 1'b1);
    #1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].din, vecs[i].rdy);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_sel, vecs[i].sel_chk,
                  vecs[i].e_gnt, vecs[i].e_ack, vecs[i].e_data);
    end

    // Backpressure: ptr is now 1; requester 1 is granted with ready low,
    // its operand changes meanwhile, and the captured value must hold.
    applyStimulus(1'b0, 4'b0010, 32'h13125510, 1'b0);
    step();
    checkOutput("bp_grant", 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0000, 8'h55);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b0010, 32'h13127710, 1'b0);
      step();
      checkOutput($sformatf("bp_hold%0d", i), 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0000, 8'h55);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_ack", 1'b1, 2'd1, 1'b1, 4'b0010, 4'b0010, 8'h55);
    applyStimulus(1'b0, 4'b0000, DEF, 1'b1);
    step();
    checkOutput("bp_done", 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0000, 8'h55);

    // Wrap-around: ptr is 2, requester 3 wins; then 0 must beat 3.
    applyStimulus(1'b0, 4'b1000, DEF, 1'b1);
    step();
    checkOutput("wrap_g3", 1'b1, 2'd3, 1'b1, 4'b1000, 4'b1000, 8'h13);
    applyStimulus(1'b0, 4'b1001, DEF, 1'b1);
    step();
    checkOutput("wrap_idle", 1'b0, 2'd3, 1'b0, 4'b0000, 4'b0000, 8'h13);
    step();
    checkOutput("wrap_g0", 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0001, 8'h10);
    applyStimulus(1'b0, 4'b0000, DEF, 1'b1);
    step();
    checkOutput("wrap_done", 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 8'h10);

    // Reset while BUSY: ptr is 1 here, so after reset req=1001 must pick 0.
    applyStimulus(1'b0, 4'b0100, DEF, 1'b0);
    step();
    checkOutput("rst_busy", 1'b1, 2'd2, 1'b1, 4'b0100, 4'b0000, 8'h12);
    applyStimulus(1'b1, 4'b0100, DEF, 1'b1);
    #1;
    cmp("rst_ack_pre", {4'd0, ack}, 8'h04);
    step();
    checkOutput("rst_mid", 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 8'h00);
    applyStimulus(1'b0, 4'b1001, DEF, 1'b0);
    step();
    checkOutput("rst_ptr0", 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0000, 8'h10);
    applyStimulus(1'b1, 4'b1000, DEF, 1'b0);
    step();
    checkOutput("rst_again", 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 8'h00);
    applyStimulus(1'b0, 4'b1000, DEF, 1'b1);
    step();
    checkOutput("rst_g3", 1'b1, 2'd3, 1'b1, 4'b1000, 4'b1000, 8'h13);

    // Single requester is granted every other cycle.
    step();
    checkOutput("single_idle", 1'b0, 2'd3, 1'b0, 4'b0000, 4'b0000, 8'h13);
    step();
    checkOutput("single_g3", 1'b1, 2'd3, 1'b1, 4'b1000, 4'b1000, 8'h13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
